// File: rtl/div_issue_arbiter.sv
// Round-robin arbiter sharing one div_unit among NUM_REQ issue ports, with an in-flight credit limit.
// Latency: a request accepted in cycle N drives div_* in cycle N+1; back-to-back issue while div_ready is high.
// Backpressure: the slot holds while div_valid & ~div_ready; issue stalls at MAX_INFLIGHT. Optional counters: DIV_ARB_PERF_EN.

package div_arb_pkg;
  typedef struct packed {
    logic is_signed;  // signed division
    logic is_rem;     // return remainder instead of quotient
    logic is_word;    // 32-bit word operation
  } div_decode_t;
endpackage

module div_issue_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*RS_ID_WIDTH-1:0]        req_rs_id,
  input  logic [NUM_REQ*5-1:0]                  req_reg_addr,
  input  logic [NUM_REQ*32-1:0]                 req_op1,
  input  logic [NUM_REQ*32-1:0]                 req_op2,
  input  logic [NUM_REQ*$bits(div_decode_t)-1:0] req_control,
  output logic                                  div_valid,
  input  logic                                  div_ready,
  output logic [RS_ID_WIDTH-1:0]                div_rs_id,
  output logic [4:0]                            div_reg_addr,
  output logic [31:0]                           div_op1,
  output logic [31:0]                           div_op2,
  output div_decode_t                           div_control,
  input  logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [2:0]                            inflight
`ifdef DIV_ARB_PERF_EN
  ,
  output logic [31:0]                           stall_cycles,
  output logic [31:0]                           credit_stall_cycles
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW = $bits(div_decode_t);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] scan_idx;
  logic          grant_found;
  logic          slot_free;
  logic          retire;
  logic [2:0]    inflight_base;
  logic          can_issue;
  logic          accept;

  // Credit check: a retirement this cycle returns its credit immediately; clamp so a stray retire at 0 cannot wrap.
  always_comb begin
    retire        = res_valid & res_ready;
    slot_free     = ~div_valid | div_ready;
    inflight_base = (retire && inflight != 3'd0) ? inflight - 3'd1 : inflight;
    can_issue     = slot_free & ({1'b0, inflight_base} < 4'(MAX_INFLIGHT));
  end

  // Round-robin scan from rr_ptr: first valid port in rotated order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Only the winning port sees ready, and only when the slot and a credit are both available.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (!rst && grant_found && can_issue) begin
      req_ready[grant_idx] = 1'b1;
      accept               = 1'b1;
    end
  end

  // Issue slot and round-robin pointer: load on accept, drain when the divider takes the op, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_valid    <= 1'b0;
      div_rs_id    <= '0;
      div_reg_addr <= '0;
      div_op1      <= '0;
      div_op2      <= '0;
      div_control  <= '0;
      rr_ptr       <= '0;
    end else if (slot_free) begin
      if (accept) begin
        div_valid    <= 1'b1;
        div_rs_id    <= req_rs_id[grant_idx*RS_ID_WIDTH +: RS_ID_WIDTH];
        div_reg_addr <= req_reg_addr[grant_idx*5 +: 5];
        div_op1      <= req_op1[grant_idx*32 +: 32];
        div_op2      <= req_op2[grant_idx*32 +: 32];
        div_control  <= div_decode_t'(req_control[grant_idx*DW +: DW]);
        if (int'(grant_idx) == NUM_REQ - 1) rr_ptr <= '0;
        else                                rr_ptr <= grant_idx + 1'b1;
      end else begin
        div_valid <= 1'b0;
      end
    end
  end

  // In-flight count covers the issue slot plus ops inside the divider; a retire at 0 holds at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 3'd0;
    end else if (accept && !retire) begin
      inflight <= inflight + 3'd1;
    end else if (!accept && retire && inflight != 3'd0) begin
      inflight <= inflight - 3'd1;
    end
  end

`ifndef SYNTHESIS
  // A retirement with nothing in flight means the divider handshake is out of step with issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(retire && inflight == 3'd0))
        else $error("div_issue_arbiter: retirement observed with inflight=0");
    end
  end
`endif

`ifdef DIV_ARB_PERF_EN
  // Count divider backpressure cycles and cycles where requests wait only for a credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles        <= '0;
      credit_stall_cycles <= '0;
    end else begin
      if (div_valid && !div_ready)                 stall_cycles        <= stall_cycles + 32'd1;
      if ((|req_valid) && slot_free && !can_issue) credit_stall_cycles <= credit_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
